instruction_loader: RTL and testbench

Writer side of the byte-wide, big-endian instruction memory. Accepts 16-bit instruction words over a valid/ready stream from a boot/debug source and writes each word as two bytes: high byte at the even address, low byte at address+1. Holds the CPU while loading so the PC fetch path never sees a half-written program.

---
 rtl/cpu_mem_pkg.sv | 32 +++
 rtl/instruction_loader.sv | 187 ++++++++++++++++++
 tb/tb_instruction_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Definitions shared by the instruction-memory writer (instruction_loader)
// and the fetch side. Holds the loader FSM state encoding and the memory
// geometry constants.
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int INSTR_W    = 16;   // instruction word width
    localparam int BYTE_W     = 8;    // instruction memory is byte-wide
    localparam int IMEM_BYTES = 128;  // default instruction memory depth

    // Loader FSM encoding, kept as plain constants so legacy code that
    // compares against raw state values keeps working.
    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE      = 3'd0;
    localparam loader_state_t ST_WAIT_WORD = 3'd1;
    localparam loader_state_t ST_WR_HI     = 3'd2;
    localparam loader_state_t ST_WR_LO     = 3'd3;
    localparam loader_state_t ST_DONE      = 3'd4;

    // Big-endian split of an instruction word into its memory bytes.
    function automatic logic [BYTE_W-1:0] hi_byte(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1:BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] lo_byte(input logic [INSTR_W-1:0] w);
        return w[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
// Writer side of the byte-wide, big-endian instruction memory. Accepts
// 16-bit words over a valid/ready stream and writes each one as two bytes
// (high byte at the even address, low byte at address+1), holding the CPU
// for the whole load so fetch never sees a half-written program.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   defined   -> Checksum is the modulo-2^16 sum of the words captured since
//                the last accepted Start
//   undefined -> Checksum is tied to 0 and no adder is built
//
// Parameters
//   MEM_BYTES  instruction memory depth in bytes (even)
//   BASE_ADDR  byte address of the first word written (even)
//   NUM_W      width of NumWords
//
// Ports
//   Clock      rising-edge clock
//   Reset      asynchronous, active-high reset
//   Start      one-cycle load request, sampled in IDLE only
//   NumWords   number of words to load, sampled with Start
//   WordValid  source presents a word on WordIn
//   WordIn     instruction word, [15:8] high byte, [7:0] low byte
//   WordReady  loader accepts WordIn this cycle
//   MemWrEn    byte write strobe
//   MemWrAddr  byte write address (0 when MemWrEn=0)
//   MemWrData  byte write data (0 when MemWrEn=0)
//   CpuHold    holds the CPU/PC while a load is in progress
//   Busy       FSM is not IDLE
//   Done       one-cycle pulse on successful completion
//   Error      sticky overflow flag, cleared by the next accepted Start
//   Checksum   running word sum (see macro above)
// ---------------------------------------------------------------------------
module instruction_loader
    import cpu_mem_pkg::*;
#(
    parameter int          MEM_BYTES = IMEM_BYTES,
    parameter logic [15:0] BASE_ADDR = 16'd0,
    parameter int          NUM_W     = 7
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [NUM_W-1:0]   NumWords,
    input  logic               WordValid,
    input  logic [INSTR_W-1:0] WordIn,
    output logic               WordReady,
    output logic               MemWrEn,
    output logic [15:0]        MemWrAddr,
    output logic [BYTE_W-1:0]  MemWrData,
    output logic               CpuHold,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [15:0]        Checksum
);

    // Highest legal byte address, widened so the bound check cannot wrap.
    localparam logic [31:0] LAST_BYTE = 32'(MEM_BYTES - 1);

    loader_state_t        state;
    loader_state_t        state_nxt;
    logic [15:0]          addr;
    logic [NUM_W-1:0]     rem;
    logic [INSTR_W-1:0]   word;
    logic                 error_q;
    logic                 overflow;
    logic                 accept;
    logic                 start_ok;

    // The low byte of the next word would land past the end of memory.
    assign overflow = ({16'd0, addr} + 32'd1) > LAST_BYTE;
    assign accept   = (state == ST_WAIT_WORD) && !overflow && WordValid;
    assign start_ok = (state == ST_IDLE) && Start;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt = (NumWords == '0) ? ST_DONE : ST_WAIT_WORD;
                end
            end
            ST_WAIT_WORD: begin
                if (overflow) begin
                    state_nxt = ST_IDLE;
                end else if (WordValid) begin
                    state_nxt = ST_WR_HI;
                end
            end
            ST_WR_HI: state_nxt = ST_WR_LO;
            ST_WR_LO: state_nxt = (rem == NUM_W'(1)) ? ST_DONE : ST_WAIT_WORD;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, address, remaining count, holding register, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            addr    <= '0;
            rem     <= '0;
            word    <= '0;
            error_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        addr    <= BASE_ADDR;
                        rem     <= NumWords;
                        error_q <= 1'b0;
                    end
                end
                ST_WAIT_WORD: begin
                    if (overflow) begin
                        error_q <= 1'b1;
                    end else if (WordValid) begin
                        word <= WordIn;
                    end
                end
                ST_WR_LO: begin
                    addr <= addr + 16'd2;
                    rem  <= rem - NUM_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        WordReady = 1'b0;
        MemWrEn   = 1'b0;
        MemWrAddr = '0;
        MemWrData = '0;
        case (state)
            ST_WAIT_WORD: WordReady = !overflow;
            ST_WR_HI: begin
                MemWrEn   = 1'b1;
                MemWrAddr = addr;
                MemWrData = hi_byte(word);
            end
            ST_WR_LO: begin
                MemWrEn   = 1'b1;
                MemWrAddr = addr + 16'd1;
                MemWrData = lo_byte(word);
            end
            default: ;
        endcase
    end

    assign Busy    = (state != ST_IDLE);
    assign CpuHold = (state != ST_IDLE);
    assign Done    = (state == ST_DONE);
    assign Error   = error_q;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sum <= '0;
        end else if (start_ok) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + WordIn;
        end
    end

    assign Checksum = sum;
`else
    logic unused_cs;
    assign unused_cs = accept & start_ok;
    assign Checksum  = '0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_loader
// Drives two loader instances (base address 0 and base address 126) from a
// shared word stream and compares the observed byte-write sequence, Done,
// Error and Checksum against a reference built from the load rules.
// ---------------------------------------------------------------------------
module tb_instruction_loader;

    localparam int MEM = 128;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        start_a, start_b;
    logic [6:0]  NumWords;
    logic        WordValid;
    logic [15:0] WordIn;

    logic        WordReady_a, MemWrEn_a, CpuHold_a, Busy_a, Done_a, Error_a;
    logic [15:0] MemWrAddr_a, Checksum_a;
    logic [7:0]  MemWrData_a;
    logic        WordReady_b, MemWrEn_b, CpuHold_b, Busy_b, Done_b, Error_b;
    logic [15:0] MemWrAddr_b, Checksum_b;
    logic [7:0]  MemWrData_b;

    always #5 Clock = ~Clock;

    instruction_loader #(.MEM_BYTES(MEM), .BASE_ADDR(16'd0), .NUM_W(7)) dut_a (
        .Clock(Clock), .Reset(Reset), .Start(start_a), .NumWords(NumWords),
        .WordValid(WordValid), .WordIn(WordIn), .WordReady(WordReady_a),
        .MemWrEn(MemWrEn_a), .MemWrAddr(MemWrAddr_a), .MemWrData(MemWrData_a),
        .CpuHold(CpuHold_a), .Busy(Busy_a), .Done(Done_a), .Error(Error_a),
        .Checksum(Checksum_a)
    );

    instruction_loader #(.MEM_BYTES(MEM), .BASE_ADDR(16'd126), .NUM_W(7)) dut_b (
        .Clock(Clock), .Reset(Reset), .Start(start_b), .NumWords(NumWords),
        .WordValid(WordValid), .WordIn(WordIn), .WordReady(WordReady_b),
        .MemWrEn(MemWrEn_b), .MemWrAddr(MemWrAddr_b), .MemWrData(MemWrData_b),
        .CpuHold(CpuHold_b), .Busy(Busy_b), .Done(Done_b), .Error(Error_b),
        .Checksum(Checksum_b)
    );

    // Selected-instance views used by the stream driver.
    bit          sel_r = 1'b0;
    logic        rdy_s, busy_s, err_s, wren_s;
    logic [15:0] sum_s;
    assign rdy_s  = sel_r ? WordReady_b : WordReady_a;
    assign busy_s = sel_r ? Busy_b      : Busy_a;
    assign err_s  = sel_r ? Error_b     : Error_a;
    assign wren_s = sel_r ? MemWrEn_b   : MemWrEn_a;
    assign sum_s  = sel_r ? Checksum_b  : Checksum_a;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- write monitor ----------------
    typedef struct {
        int a;
        int d;
        int t;
    } wr_t;

    wr_t wq_a[$];
    wr_t wq_b[$];
    int  done_a = 0;
    int  done_b = 0;
    int  cyc    = 0;

    always @(negedge Clock) begin
        cyc++;
        if (MemWrEn_a) wq_a.push_back(wr_t'{int'(MemWrAddr_a), int'(MemWrData_a), cyc});
        else check("idle_bus_a", {8'd0, MemWrAddr_a, MemWrData_a}, 32'd0);
        if (MemWrEn_b) wq_b.push_back(wr_t'{int'(MemWrAddr_b), int'(MemWrData_b), cyc});
        else check("idle_bus_b", {8'd0, MemWrAddr_b, MemWrData_b}, 32'd0);
        if (Done_a) done_a++;
        if (Done_b) done_b++;
        check("hold_vs_busy_a", CpuHold_a, Busy_a);
        check("hold_vs_busy_b", CpuHold_b, Busy_b);
        check("ready_during_wr_a", WordReady_a & MemWrEn_a, 0);
        check("ready_during_wr_b", WordReady_b & MemWrEn_b, 0);
    end

    // ---------------- reference model ----------------
    int  words[$];
    wr_t exp_q[$];
    bit  exp_err;
    int  exp_sum;

    // Bytes land big-endian from the base address; a word whose low byte
    // would fall beyond memory ends the load with an error and is not taken.
    task automatic model(input int base, input int n);
        exp_q.delete();
        exp_err = 1'b0;
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            a = base + 2 * i;
            if (a + 1 > MEM - 1) begin
                exp_err = 1'b1;
                break;
            end
            exp_q.push_back(wr_t'{a, words[i] / 256, 0});
            exp_q.push_back(wr_t'{a + 1, words[i] % 256, 0});
            exp_sum = (exp_sum + words[i]) % 65536;
        end
    endtask

    task automatic verify(input bit sel, input string tag);
        wr_t q[$];
        int  nd;
        if (sel) begin
            q  = wq_b;
            nd = done_b;
        end else begin
            q  = wq_a;
            nd = done_a;
        end
        check({tag, "_nwrites"}, q.size(), exp_q.size());
        for (int k = 0; k < q.size() && k < exp_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), q[k].a, exp_q[k].a);
            check($sformatf("%s_data%0d", tag, k), q[k].d, exp_q[k].d);
            if (k % 2 == 1) check($sformatf("%s_adjacent%0d", tag, k), q[k].t, q[k-1].t + 1);
        end
        check({tag, "_done_count"}, nd, exp_err ? 0 : 1);
        check({tag, "_error"}, err_s, exp_err);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, sum_s, exp_sum);
`else
        check({tag, "_checksum"}, sum_s, 0);
`endif
        check({tag, "_idle_after"}, busy_s, 0);
        wq_a.delete();
        wq_b.delete();
        done_a = 0;
        done_b = 0;
    endtask

    // Start a load on the selected instance and feed words[] with valid held,
    // optionally pausing for gap_len ready cycles before word gap_idx.
    task automatic load(input bit sel, input int n, input int gap_idx, input int gap_len);
        int  idx     = 0;
        int  gap_cnt = 0;
        bit  gap_on  = 1'b0;
        bit  first   = 1'b1;
        bit  fin     = 1'b0;
        bit  in_gap;
        sel_r = sel;
        @(posedge Clock); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        NumWords  = 7'(n);
        WordValid = 1'b0;
        @(posedge Clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_gap    = (idx == gap_idx) && (gap_cnt < gap_len);
            WordValid = (idx < words.size()) && !in_gap;
            WordIn    = (idx < words.size()) ? 16'(words[idx]) : 16'h0;
            @(negedge Clock);
            if (first) check("error_cleared_on_start", err_s, 0);
            first = 1'b0;
            if (in_gap) begin
                if (gap_on) begin
                    check("gap_ready_held", rdy_s, 1);
                    check("gap_no_write", wren_s, 0);
                end
                if (rdy_s) gap_on = 1'b1;
                if (gap_on) gap_cnt++;
            end
            if (WordValid && rdy_s) idx++;
            if (!busy_s) begin
                fin = 1'b1;
                break;
            end
            @(posedge Clock); #1;
        end
        WordValid = 1'b0;
        check("load_finished_in_budget", fin, 1);
    endtask

    task automatic set_words2(input int w0, input int w1);
        words.delete();
        words.push_back(w0);
        words.push_back(w1);
    endtask

    initial begin
        bit found;
        int n;
        Reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        NumWords = '0; WordValid = 1'b0; WordIn = '0;
        #12;
        check("rst_outputs_a", {WordReady_a, MemWrEn_a, CpuHold_a, Busy_a, Done_a, Error_a}, 0);
        check("rst_bus_a", {MemWrAddr_a, MemWrData_a, 8'd0}, 0);
        check("rst_checksum_a", Checksum_a, 0);
        check("rst_outputs_b", {WordReady_b, MemWrEn_b, CpuHold_b, Busy_b, Done_b, Error_b}, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // Two words, valid held.
        set_words2(16'hA1B2, 16'h0C3D);
        model(0, 2); load(0, 2, -1, 0); verify(0, "two_words");

        // Same load with a 4-cycle source stall before the second word.
        model(0, 2); load(0, 2, 1, 4); verify(0, "stall");

        // Base 126: first word fits, second overflows.
        set_words2(16'h1234, 16'h5678);
        model(126, 2); load(1, 2, -1, 0); verify(1, "overflow");
        @(posedge Clock); @(posedge Clock); @(negedge Clock);
        check("error_sticky", Error_b, 1);
        check("overflow_no_write_128", wq_b.size(), 0);

        // Error clears on the next accepted Start; single word fits.
        words.delete(); words.push_back(16'hBEEF);
        model(126, 1); load(1, 1, -1, 0); verify(1, "after_error");

        // Reset in WR_LO of the first word.
        set_words2(16'hA1B2, 16'h0C3D);
        sel_r = 1'b0;
        @(posedge Clock); #1; start_a = 1'b1; NumWords = 7'd2;
        @(posedge Clock); #1; start_a = 1'b0; WordValid = 1'b1; WordIn = 16'hA1B2;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (MemWrEn_a && MemWrAddr_a == 16'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_wr_lo", found, 1);
        #1 Reset = 1'b1;
        #1;
        check("async_rst_outputs", {WordReady_a, MemWrEn_a, CpuHold_a, Busy_a, Done_a, Error_a}, 0);
        check("async_rst_bus", {MemWrAddr_a, MemWrData_a, 8'd0}, 0);
        check("async_rst_checksum", Checksum_a, 0);
        #1 Reset = 1'b0;
        WordValid = 1'b0;
        @(negedge Clock);
        wq_a.delete(); wq_b.delete(); done_a = 0; done_b = 0;
        words.delete(); words.push_back(16'hFFFF);
        model(0, 1); load(0, 1, -1, 0); verify(0, "post_reset");

        // NumWords=0, plus a Start while busy that must be ignored.
        @(posedge Clock); #1; start_a = 1'b1; NumWords = 7'd0;
        @(posedge Clock); #1; NumWords = 7'd2;
        @(negedge Clock);
        check("zero_done_pulse", Done_a, 1);
        check("zero_busy", Busy_a, 1);
        @(posedge Clock); #1; start_a = 1'b0;
        @(negedge Clock);
        check("zero_back_idle", {Busy_a, Done_a}, 0);
        @(posedge Clock); @(negedge Clock);
        check("busy_start_ignored", {Busy_a, CpuHold_a}, 0);
        words.delete();
        model(0, 0); verify(0, "zero_words");

        // Checksum wrap.
        set_words2(16'hFFFF, 16'h0002);
        model(0, 2); load(0, 2, -1, 0); verify(0, "checksum_wrap");

        // Randomized loads on both instances.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom_range(0, 65535));
            model(0, n);
            load(0, n, $urandom_range(0, n - 1), $urandom_range(0, 3));
            verify(0, $sformatf("rand_a%0d", r));
        end
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom_range(0, 65535));
            model(126, n);
            load(1, n, -1, 0);
            verify(1, $sformatf("rand_b%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
